// File: rtl/screen_flow_ctrl.sv
// rtl/screen_flow_ctrl.sv - game-flow screen sequencer with frame streaming to the matrix row buffer
//
// Sequences START -> PLAY <-> PAUSE, PLAY -> OVER -> START from IR ENTER
// presses, the engine's game_over level and a timeout, and streams the
// selected frame into the display row buffer one row per cycle.
//
// Ports:
//   CLOCK_50       in   system clock
//   reset_n        in   asynchronous active-low reset
//   key_valid      in   one-cycle strobe, key_word holds a new IR word
//   key_word       in   decoded IR word
//   game_over      in   level from the game engine
//   tick           in   one-cycle game-rate pulse
//   game_row_data  in   game grid row at game_row_addr (combinational read)
//   game_row_addr  out  game grid row being read
//   disp_row_addr  out  display buffer write row
//   disp_row_data  out  display buffer write data
//   disp_row_we    out  display buffer write enable
//   game_run       out  game engine enable, high only in PLAY
//   game_restart   out  one-cycle engine reinitialise pulse
//   state          out  0=START 1=PLAY 2=PAUSE 3=OVER
//   frame_busy     out  high from scan start through the last row write

module screen_flow_ctrl #(
    parameter int                    ROWS          = 16,
    parameter int                    COLS          = 16,
    parameter logic [31:0]           ENTER_CODE    = 32'h20DF5AA5,
    parameter logic [ROWS*COLS-1:0]  START_PATTERN = '0,
    parameter logic [ROWS*COLS-1:0]  END_PATTERN   = '0,
    parameter int                    BLINK_TICKS   = 2,
    parameter int                    END_TIMEOUT   = 40
) (
    input  logic                      CLOCK_50,
    input  logic                      reset_n,
    input  logic                      key_valid,
    input  logic [31:0]               key_word,
    input  logic                      game_over,
    input  logic                      tick,
    input  logic [COLS-1:0]           game_row_data,
    output logic [$clog2(ROWS)-1:0]   game_row_addr,
    output logic [$clog2(ROWS)-1:0]   disp_row_addr,
    output logic [COLS-1:0]           disp_row_data,
    output logic                      disp_row_we,
    output logic                      game_run,
    output logic                      game_restart,
    output logic [1:0]                state,
    output logic                      frame_busy
);

    localparam int AW = $clog2(ROWS);
    localparam int TW = $clog2(END_TIMEOUT + 1);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    localparam logic [AW-1:0] LAST_ROW   = AW'(ROWS - 1);
    localparam logic [TW-1:0] TO_LIMIT   = TW'(END_TIMEOUT);
    localparam logic [TW-1:0] TO_MAX     = {TW{1'b1}};
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic [1:0]      state_nxt;
    logic            restart_nxt;
    logic            enter;
    logic            blink_wrap;
    logic            trigger;
    logic            scan_start;
    logic [BW-1:0]   blink_cnt;
    logic            blank_phase;
    logic [TW-1:0]   to_cnt;
    logic            refresh_pending;
    logic            scan_active;
    logic [AW-1:0]   row_cnt;
    logic [COLS-1:0] src_row;

    assign enter = key_valid && (key_word == ENTER_CODE);

    always_comb begin
        state_nxt   = state;
        restart_nxt = 1'b0;
        case (state)
            S_START: begin
                if (enter) begin
                    state_nxt   = S_PLAY;
                    restart_nxt = 1'b1;
                end
            end
            S_PLAY: begin
                // game_over outranks a simultaneous ENTER
                if (game_over) begin
                    state_nxt = S_OVER;
                end else if (enter) begin
                    state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (enter) begin
                    state_nxt = S_PLAY;
                end
            end
            default: begin
                if (enter || (to_cnt >= TO_LIMIT)) begin
                    state_nxt = S_START;
                end
            end
        endcase
    end

    assign blink_wrap = (state == S_PAUSE) && tick && (blink_cnt == BLINK_LAST);

    // Anything that can change what the panel should show requests a frame.
    assign trigger = (tick && ((state == S_START) || (state == S_PLAY)))
                   || (state_nxt != state)
                   || blink_wrap;

    // A new scan only begins from idle; triggers during a scan just leave
    // refresh_pending set so a follow-up scan fixes any stale rows.
    assign scan_start = !scan_active && refresh_pending;

    // Source is taken from the live state, so a state change mid-scan
    // switches the remaining rows immediately.
    always_comb begin
        src_row = '0;
        case (state)
            S_START: src_row = START_PATTERN[int'(row_cnt)*COLS +: COLS];
            S_PLAY:  src_row = game_row_data;
            S_PAUSE: src_row = blank_phase ? '0 : game_row_data;
            default: src_row = END_PATTERN[int'(row_cnt)*COLS +: COLS];
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_START;
            game_restart <= 1'b0;
        end else begin
            state        <= state_nxt;
            game_restart <= restart_nxt;
        end
    end

    // Blink counter sits at zero outside PAUSE, so every entry into PAUSE
    // begins with a full visible half-period.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blank_phase <= 1'b0;
        end else if (state != S_PAUSE) begin
            blink_cnt   <= '0;
            blank_phase <= 1'b0;
        end else if (tick) begin
            if (blink_wrap) begin
                blink_cnt   <= '0;
                blank_phase <= ~blank_phase;
            end else begin
                blink_cnt   <= blink_cnt + 1'b1;
            end
        end
    end

    // Timeout counter is held clear outside OVER and saturates inside it.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (state != S_OVER) begin
            to_cnt <= '0;
        end else if (tick && (to_cnt != TO_MAX)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            refresh_pending <= 1'b1;
        end else if (trigger) begin
            refresh_pending <= 1'b1;
        end else if (scan_start) begin
            refresh_pending <= 1'b0;
        end
    end

    // Row read at row_cnt in one cycle is written to the buffer the next.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            scan_active   <= 1'b0;
            row_cnt       <= '0;
            disp_row_we   <= 1'b0;
            disp_row_addr <= '0;
            disp_row_data <= '0;
        end else if (scan_start) begin
            scan_active   <= 1'b1;
            row_cnt       <= '0;
            disp_row_we   <= 1'b0;
        end else if (scan_active) begin
            disp_row_we   <= 1'b1;
            disp_row_addr <= row_cnt;
            disp_row_data <= src_row;
            if (row_cnt == LAST_ROW) begin
                scan_active <= 1'b0;
                row_cnt     <= '0;
            end else begin
                row_cnt     <= row_cnt + 1'b1;
            end
        end else begin
            disp_row_we   <= 1'b0;
        end
    end

    assign game_row_addr = row_cnt;
    assign game_run      = (state == S_PLAY);
    assign frame_busy    = scan_active || disp_row_we;

endmodule

// File: tb/tb_screen_flow_ctrl.sv
// tb/tb_screen_flow_ctrl.sv - directed self-checking bench for screen_flow_ctrl

module tb_screen_flow_ctrl;

    localparam int          ROWS  = 16;
    localparam int          COLS  = 16;
    localparam logic [31:0] ENTER = 32'h20DF5AA5;
    localparam logic [31:0] OTHER = 32'h20DF6A95;
    localparam logic [7:0]  GSEL  = 8'h9E;

    localparam int K_START = 0;
    localparam int K_END   = 1;
    localparam int K_GAME  = 2;
    localparam int K_ZERO  = 3;

    function automatic logic [15:0] exp_row(input int kind, input int r);
        logic [3:0] rr;
        rr = 4'(r);
        case (kind)
            K_START: exp_row = {4'hA, rr, 8'h5A};
            K_END:   exp_row = {rr, 4'h3, 8'hC0};
            K_GAME:  exp_row = {GSEL, 4'h0, rr};
            default: exp_row = 16'h0000;
        endcase
    endfunction

    function automatic logic [255:0] mk_pat(input int kind);
        logic [255:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) v[r*16 +: 16] = exp_row(kind, r);
        return v;
    endfunction

    localparam logic [255:0] SP = mk_pat(K_START);
    localparam logic [255:0] EP = mk_pat(K_END);

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic        key_valid;
    logic [31:0] key_word;
    logic        game_over;
    logic        tick;
    logic [15:0] game_row_data;
    logic [3:0]  game_row_addr;
    logic [3:0]  disp_row_addr;
    logic [15:0] disp_row_data;
    logic        disp_row_we;
    logic        game_run;
    logic        game_restart;
    logic [1:0]  state;
    logic        frame_busy;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  q_addr[$];
    logic [15:0] q_data[$];

    screen_flow_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .ENTER_CODE(ENTER),
        .START_PATTERN(SP), .END_PATTERN(EP),
        .BLINK_TICKS(2), .END_TIMEOUT(40)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .key_valid(key_valid),
        .key_word(key_word), .game_over(game_over), .tick(tick),
        .game_row_data(game_row_data), .game_row_addr(game_row_addr),
        .disp_row_addr(disp_row_addr), .disp_row_data(disp_row_data),
        .disp_row_we(disp_row_we), .game_run(game_run),
        .game_restart(game_restart), .state(state), .frame_busy(frame_busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    assign game_row_data = {GSEL, 4'h0, game_row_addr};

    always @(negedge CLOCK_50) begin
        if (disp_row_we) begin
            q_addr.push_back(disp_row_addr);
            q_data.push_back(disp_row_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic qclear();
        q_addr.delete();
        q_data.delete();
    endtask

    task automatic check_frame(input string tag, input int kind, input int off);
        for (int r = 0; r < ROWS; r++) begin
            if (off + r < q_addr.size()) begin
                chk({tag, "_addr"}, 32'(q_addr[off+r]), 32'(r));
                chk({tag, "_data"}, 32'(q_data[off+r]), 32'(exp_row(kind, r)));
            end else begin
                chk({tag, "_missing"}, 32'(q_addr.size()), 32'(off + r + 1));
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        key_valid = 1'b0;
        key_word  = 32'h0;
        game_over = 1'b0;
        tick      = 1'b0;
        cyc(3);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_we", 32'(disp_row_we), 32'd0);
        chk("rst_run", 32'(game_run), 32'd0);
        chk("rst_restart", 32'(game_restart), 32'd0);
        chk("rst_busy", 32'(frame_busy), 32'd0);
        chk("rst_gaddr", 32'(game_row_addr), 32'd0);
        chk("rst_daddr", 32'(disp_row_addr), 32'd0);
        chk("rst_ddata", 32'(disp_row_data), 32'd0);

        // first frame after reset
        qclear();
        reset_n = 1'b1;
        cyc(2);
        chk("boot_busy", 32'(frame_busy), 32'd1);
        cyc(30);
        chk("boot_cnt", 32'(q_addr.size()), 32'd16);
        check_frame("boot", K_START, 0);
        chk("boot_state", 32'(state), 32'd0);
        chk("boot_run", 32'(game_run), 32'd0);
        chk("boot_idle", 32'(frame_busy), 32'd0);

        // START -> PLAY with a single restart pulse
        qclear();
        key_valid = 1'b1; key_word = ENTER;
        cyc(1);
        key_valid = 1'b0;
        chk("play_state", 32'(state), 32'd1);
        chk("play_restart", 32'(game_restart), 32'd1);
        chk("play_run", 32'(game_run), 32'd1);
        cyc(1);
        chk("play_restart_off", 32'(game_restart), 32'd0);
        cyc(30);
        chk("play_cnt", 32'(q_addr.size()), 32'd16);
        check_frame("play", K_GAME, 0);

        // foreign key is ignored
        qclear();
        key_valid = 1'b1; key_word = OTHER;
        cyc(1);
        key_valid = 1'b0;
        chk("other_state", 32'(state), 32'd1);
        cyc(30);
        chk("other_nowrite", 32'(q_addr.size()), 32'd0);

        // PLAY -> PAUSE
        key_valid = 1'b1; key_word = ENTER;
        cyc(1);
        key_valid = 1'b0;
        chk("pause_state", 32'(state), 32'd2);
        chk("pause_run", 32'(game_run), 32'd0);
        chk("pause_restart", 32'(game_restart), 32'd0);
        cyc(30);
        chk("pause_cnt", 32'(q_addr.size()), 32'd16);
        check_frame("pause", K_GAME, 0);

        // game_over has no effect while paused
        game_over = 1'b1;
        cyc(1);
        game_over = 1'b0;
        chk("pause_go_ignored", 32'(state), 32'd2);

        // blink: visible for two ticks, blank for two
        qclear();
        do_tick(); cyc(30);
        chk("blink_t1_nowrite", 32'(q_addr.size()), 32'd0);
        do_tick(); cyc(30);
        chk("blink_t2_cnt", 32'(q_addr.size()), 32'd16);
        check_frame("blink_blank", K_ZERO, 0);
        do_tick(); cyc(30);
        chk("blink_t3_cnt", 32'(q_addr.size()), 32'd16);
        do_tick(); cyc(30);
        chk("blink_t4_cnt", 32'(q_addr.size()), 32'd32);
        check_frame("blink_vis", K_GAME, 16);

        // PAUSE -> PLAY without restart
        qclear();
        key_valid = 1'b1; key_word = ENTER;
        cyc(1);
        key_valid = 1'b0;
        chk("resume_state", 32'(state), 32'd1);
        chk("resume_restart", 32'(game_restart), 32'd0);
        cyc(30);
        check_frame("resume", K_GAME, 0);

        // game_over beats a simultaneous ENTER
        qclear();
        key_valid = 1'b1; key_word = ENTER; game_over = 1'b1;
        cyc(1);
        key_valid = 1'b0; game_over = 1'b0;
        chk("over_state", 32'(state), 32'd3);
        chk("over_run", 32'(game_run), 32'd0);
        cyc(30);
        chk("over_cnt", 32'(q_addr.size()), 32'd16);
        check_frame("over", K_END, 0);

        // auto-return after 40 ticks
        qclear();
        for (int i = 0; i < 39; i++) begin
            do_tick(); cyc(1);
        end
        chk("timeout_39_state", 32'(state), 32'd3);
        chk("timeout_39_nowrite", 32'(q_addr.size()), 32'd0);
        do_tick();
        cyc(1);
        chk("timeout_40_state", 32'(state), 32'd0);
        cyc(30);
        chk("timeout_cnt", 32'(q_addr.size()), 32'd16);
        check_frame("timeout", K_START, 0);

        // tick during a scan queues exactly one follow-up frame
        qclear();
        do_tick();
        cyc(6);
        chk("midscan_busy", 32'(frame_busy), 32'd1);
        do_tick();
        cyc(60);
        chk("rescan_cnt", 32'(q_addr.size()), 32'd32);
        check_frame("rescan_a", K_START, 0);
        check_frame("rescan_b", K_START, 16);

        // async reset in the middle of a scan
        do_tick();
        cyc(8);
        chk("prereset_we", 32'(disp_row_we), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_we", 32'(disp_row_we), 32'd0);
        chk("areset_busy", 32'(frame_busy), 32'd0);
        chk("areset_state", 32'(state), 32'd0);
        cyc(1);
        qclear();
        reset_n = 1'b1;
        cyc(40);
        chk("postreset_cnt", 32'(q_addr.size()), 32'd16);
        check_frame("postreset", K_START, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
